// File: rtl/id_inst_queue.sv
// Instruction queue between fetch and decode: circular buffer of {pc, inst} entries with branch flush and delay-slot keep.
// Latency: one cycle from push to out_valid; zero cycles on an empty queue when IQ_BYPASS_EN is defined.
// Backpressure: in_ready drops only when full (registered state only); out_valid holds the head until out_ready.
module id_inst_queue #(
    parameter int DEPTH  = 4,
    parameter int PC_W   = 32,
    parameter int INST_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PC_W-1:0]          in_pc,
    input  logic [INST_W-1:0]        in_inst,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PC_W-1:0]          out_pc,
    output logic [INST_W-1:0]        out_inst,
    input  logic                     flush,
    input  logic                     flush_keep,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
    localparam logic [PW-1:0] ONE     = PW'(1);

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [PW-1:0]     head_nxt;
    logic [PW-1:0]     tail_nxt;
    logic [PW-1:0]     head_pop;
    logic [PW-1:0]     remain;
    logic              push;
    logic              pop;
    logic              bypass;
    logic              wr_en;

    // Storage is deliberately not reset; validity is tracked by the pointers alone.
    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];

    assign count    = tail - head;
    assign in_ready = (count != DEPTH_C);
    assign push     = in_valid & in_ready;
    assign pop      = out_valid & out_ready;
    assign head_pop = head + {{AW{1'b0}}, pop};
    assign remain   = count - {{AW{1'b0}}, pop};

    // Head presentation, optionally short-circuiting an empty queue straight from fetch.
    always_comb begin
        bypass    = 1'b0;
        out_valid = (count != '0);
        out_pc    = pc_mem[head[AW-1:0]];
        out_inst  = inst_mem[head[AW-1:0]];
`ifdef IQ_BYPASS_EN
        if (count == '0 && !flush) begin
            bypass    = 1'b1;
            out_valid = in_valid;
            out_pc    = in_pc;
            out_inst  = in_inst;
        end
`endif
    end

    // Pointer next-state: flush discards (optionally keeping the delay-slot entry), otherwise normal push/pop.
    always_comb begin
        head_nxt = head;
        tail_nxt = tail;
        wr_en    = 1'b0;
        if (flush) begin
            head_nxt = head_pop;
            if (!flush_keep) begin
                tail_nxt = head_pop;
            end else if (remain != '0) begin
                // Oldest surviving stored entry becomes the only one; any push is dropped.
                tail_nxt = head_pop + ONE;
            end else if (push) begin
                // Nothing stored survives, so the incoming instruction is the delay slot.
                wr_en    = 1'b1;
                tail_nxt = tail + ONE;
            end else begin
                tail_nxt = head_pop;
            end
        end else if (bypass && pop) begin
            // Entry consumed directly by decode; nothing is stored.
            head_nxt = head;
            tail_nxt = tail;
        end else begin
            head_nxt = head_pop;
            if (push) begin
                wr_en    = 1'b1;
                tail_nxt = tail + ONE;
            end
        end
    end

    // Pointer registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
        end else begin
            head <= head_nxt;
            tail <= tail_nxt;
        end
    end

    // Entry storage write at the tail slot.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            pc_mem[tail[AW-1:0]]   <= in_pc;
            inst_mem[tail[AW-1:0]] <= in_inst;
        end
    end

endmodule

// File: tb/tb_id_inst_queue.sv
// Self-checking bench for id_inst_queue: scoreboard of expected {pc, inst} entries.
// Inputs driven at the falling edge, outputs sampled 1 time unit later and after the rising edge.
// Covers reset, fill/full, wrap, flush, delay-slot keep, mid-stream reset and (optionally) bypass.
module tb_id_inst_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        flush;
    logic        flush_keep;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    logic [31:0] q_pc[$];
    logic [31:0] q_inst[$];

    id_inst_queue #(.DEPTH(DEPTH), .PC_W(32), .INST_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pc      (in_pc),
        .in_inst    (in_inst),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_inst   (out_inst),
        .flush      (flush),
        .flush_keep (flush_keep),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    // One clock cycle of stimulus: check combinational outputs against the model,
    // let the edge happen, update the model, then check the registered count.
    task automatic cyc(input logic iv, input logic [31:0] pc, input logic ordy,
                       input logic fl, input logic kp);
        int          m_cnt;
        logic        byp;
        logic        exp_ov;
        logic        m_push;
        logic        m_pop;
        logic [31:0] f_pc;
        logic [31:0] f_inst;
        in_valid   = iv;
        in_pc      = pc;
        in_inst    = inst_of(pc);
        out_ready  = ordy;
        flush      = fl;
        flush_keep = kp;
        #1;
        m_cnt = q_pc.size();
        byp   = 1'b0;
`ifdef IQ_BYPASS_EN
        byp = (m_cnt == 0) && !fl;
`endif
        exp_ov = byp ? iv : (m_cnt != 0);
        chk("in_ready", {31'd0, in_ready}, {31'd0, m_cnt != DEPTH});
        chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
        if (exp_ov) begin
            chk("out_pc", out_pc, byp ? pc : q_pc[0]);
            chk("out_inst", out_inst, byp ? inst_of(pc) : q_inst[0]);
        end
        m_push = iv && (m_cnt != DEPTH);
        m_pop  = exp_ov && ordy;
        @(posedge clk);
        if (!(byp && m_push && m_pop)) begin
            if (m_pop) begin
                f_pc   = q_pc.pop_front();
                f_inst = q_inst.pop_front();
            end
            if (fl && !kp) begin
                q_pc.delete();
                q_inst.delete();
            end else if (fl && kp) begin
                if (q_pc.size() > 0) begin
                    f_pc   = q_pc[0];
                    f_inst = q_inst[0];
                    q_pc.delete();
                    q_inst.delete();
                    q_pc.push_back(f_pc);
                    q_inst.push_back(f_inst);
                end else if (m_push) begin
                    q_pc.push_back(pc);
                    q_inst.push_back(inst_of(pc));
                end
            end else if (m_push) begin
                q_pc.push_back(pc);
                q_inst.push_back(inst_of(pc));
            end
        end
        @(negedge clk);
        chk("count", {29'd0, count}, q_pc.size());
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_pc      = '0;
        in_inst    = '0;
        out_ready  = 1'b0;
        flush      = 1'b0;
        flush_keep = 1'b0;
        #1;
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Fill to full, fifth push refused, then drain in order.
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'h100 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
        chk("full_count", {29'd0, count}, 32'd4);
        cyc(1'b1, 32'h110, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("drained", {29'd0, count}, 32'd0);

        // Steady push/pop at count=2 across pointer wrap.
        cyc(1'b1, 32'h700, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h704, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b1, 32'h708 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
        chk("wrap_count", {29'd0, count}, 32'd2);
        // flush_keep without flush has no effect.
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Full flush with a same-cycle push.
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h200 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h20C, 1'b0, 1'b1, 1'b0);
        chk("flush_count", {29'd0, count}, 32'd0);
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);

        // Delay slot: pop 0x300 while flushing with keep -> 0x304 survives.
        cyc(1'b1, 32'h300, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h304, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        chk("keep_count", {29'd0, count}, 32'd1);
        chk("keep_pc", out_pc, 32'h304);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        // Empty queue: pushed entry becomes the delay slot.
        cyc(1'b1, 32'h400, 1'b0, 1'b1, 1'b1);
        chk("keep_push_count", {29'd0, count}, 32'd1);
        chk("keep_push_pc", out_pc, 32'h400);
        // Flush with keep while popping the last entry and pushing: push retained.
        cyc(1'b1, 32'h404, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Reset pulsed between edges with three entries.
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h800 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_pc    = 32'h900;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_count", {29'd0, count}, 32'd0);
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk("rst_hold_count", {29'd0, count}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        q_pc.delete();
        q_inst.delete();
        cyc(1'b1, 32'h600, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Empty queue with decode ready: bypass forwards same cycle, otherwise next cycle.
        cyc(1'b1, 32'h500, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("end_count", {29'd0, count}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_inst_queue.md
ID_INST_QUEUE -- requirements
Module: id_inst_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queue entries (power of two, >= 2).
REQ-002 SHALL have parameter PC_W, default 32, width of the stored PC field.
REQ-003 SHALL have parameter INST_W, default 32, width of the stored instruction field.
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port in_valid  input  1  fetch side presents an entry.
REQ-007 SHALL have port in_ready  output  1  queue accepts an entry.
REQ-008 SHALL have port in_pc  input  PC_W  PC of the incoming instruction.
REQ-009 SHALL have port in_inst  input  INST_W  incoming instruction word from inst SRAM.
REQ-010 SHALL have port out_valid  output  1  head entry available to decode.
REQ-011 SHALL have port out_ready  input  1  decode consumes the head entry.
REQ-012 SHALL have port out_pc  output  PC_W  PC of the head entry.
REQ-013 SHALL have port out_inst  output  INST_W  instruction of the head entry.
REQ-014 SHALL have port flush  input  1  branch redirect, discard queued entries.
REQ-015 SHALL have port flush_keep  input  1  on flush, retain one entry (delay slot).
REQ-016 SHALL have port count  output  $clog2(DEPTH)+1  number of stored entries.

Function
REQ-017 SHALL implement a circular buffer: head/tail pointers of $clog2(DEPTH)+1 bits, wrap bit as MSB; count = tail - head modulo 2^(ptr width).
REQ-018 SHALL compute push = in_valid & in_ready and pop = out_valid & out_ready.
REQ-019 SHALL drive in_ready = (count != DEPTH); in_ready SHALL NOT depend combinationally on out_ready or flush.
REQ-020 SHALL drive out_valid = (count != 0) when IQ_BYPASS_EN is undefined; out_pc/out_inst SHALL be the head entry, don't-care when out_valid=0.
REQ-021 SHALL, without flush, update count by +1 (push only), -1 (pop only), 0 (both or neither); push and pop in the same cycle are legal whenever count is between 1 and DEPTH-1.
REQ-022 SHALL preserve FIFO order across pointer wrap-around; entry pushed into slot DEPTH-1 is followed by slot 0.
REQ-023 SHALL, on flush=1 with flush_keep=0, make count=0 at the next edge; the same-cycle push is discarded; the same-cycle pop is still a valid consumption.
REQ-024 SHALL, on flush=1 with flush_keep=1, retain exactly one entry at the next edge: the oldest stored entry not popped this cycle; if none, the same-cycle pushed entry; if neither exists, count=0.
REQ-025 SHALL ignore flush_keep when flush=0.
REQ-026 SHALL hold contents and pointers unchanged when in_valid=0, out_ready=0 and flush=0.
REQ-027 SHALL give a minimum in-to-out latency of one cycle (push at edge N, out_valid at cycle N+1) when IQ_BYPASS_EN is undefined.

Reset
REQ-028 SHALL clear head, tail and count to 0 asynchronously on rst=1, independent of clk.
REQ-029 SHALL drive out_valid=0, count=0 and in_ready=1 while rst=1, including reset asserted mid-stream; storage array contents are not reset.
REQ-030 SHALL ignore push, pop and flush while rst=1 and resume on the first rising clk edge after rst deasserts.

Configuration
REQ-031 SHALL, when macro IQ_BYPASS_EN is defined, drive out_valid=in_valid and out_pc/out_inst=in_pc/in_inst combinationally when count=0 and flush=0; if out_ready=1 in that cycle the entry SHALL NOT be stored (count stays 0).
REQ-032 SHALL, when IQ_BYPASS_EN is undefined, contain no combinational path from in_* to out_*.

Verification
REQ-033 SHALL cover fill: DEPTH=4, out_ready=0, push pc 0x100,0x104,0x108,0x10C -> count=4, in_ready=0, fifth push refused; then out_ready=1 -> out_pc 0x100..0x10C in order.
REQ-034 SHALL cover wrap: continuous push/pop at count=2 for 10 cycles -> count constant 2, out_inst sequence matches input, no loss across slot 3->0.
REQ-035 SHALL cover flush: 3 entries (0x200,0x204,0x208), flush=1, flush_keep=0 with push 0x20C -> next cycle count=0, out_valid=0.
REQ-036 SHALL cover delay slot: entries 0x300,0x304, pop of 0x300 plus flush=1, flush_keep=1 -> next cycle count=1, out_pc=0x304; empty queue with push 0x400 and same flush -> count=1, out_pc=0x400.
REQ-037 SHALL cover reset: rst pulsed between clk edges with count=3 -> out_valid=0, count=0 immediately; first push after release appears one cycle later.
REQ-038 SHALL cover bypass: with IQ_BYPASS_EN, empty queue, in_valid=1, in_pc=0x500, out_ready=1 -> out_valid=1, out_pc=0x500 same cycle, count stays 0; without macro out_valid appears next cycle.
